// File: rtl/freq_meter_if.sv
// Tick/measurement interface between the window source (divider side) and freq_meter.
// The master drives the measured signal, window tick and enable; the slave returns the result.
interface freq_meter_if #(
    parameter int W = 32
);
    logic         sig_in;
    logic         gate;
    logic         st;
    logic [W-1:0] count;
    logic         valid;
    logic         ovf;
    logic         busy;

    modport master (
        output sig_in, gate, st,
        input  count, valid, ovf, busy
    );

    modport slave (
        input  sig_in, gate, st,
        output count, valid, ovf, busy
    );
endinterface

// File: rtl/freq_meter.sv
// Gated edge counter: counts synchronized rising edges of sig_in between gate ticks
// and publishes a saturating count plus overflow flag once per completed window.
module freq_meter #(
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic        clk,
    input  logic        rst,
    freq_meter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [W-1:0] ACC_MAX = '1;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   e;
    logic [W-1:0]           e_ext;
    logic [W-1:0]           acc;
    logic [W-1:0]           acc_next;
    logic                   sat;
    logic                   sat_next;
    logic                   close;
    logic [W-1:0]           count_hold;
    logic                   ovf_hold;
    logic                   valid_pulse;
    logic                   busy_flag;

    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.sig_in};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign e     = sync[SYNC_STAGES-1] & ~prev;
    assign e_ext = {{(W-1){1'b0}}, e};

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        acc_next   = acc;
        sat_next   = sat;
        close      = 1'b0;

        unique case (state)
            IDLE: begin
                acc_next = '0;
                sat_next = 1'b0;
                if (bus.st) state_next = ARM;
            end

            ARM: begin
                acc_next = '0;
                sat_next = 1'b0;
                if (!bus.st) begin
                    state_next = IDLE;
                end else if (bus.gate) begin
                    acc_next   = e_ext;
                    state_next = MEASURE;
                end
            end

            MEASURE: begin
                if (!bus.st) begin
                    // Abort wins over a coincident gate: the open window is dropped.
                    acc_next   = '0;
                    sat_next   = 1'b0;
                    state_next = IDLE;
                end else if (bus.gate) begin
                    // The edge seen on the closing tick opens the next window.
                    close    = 1'b1;
                    acc_next = e_ext;
                    sat_next = 1'b0;
                end else begin
                    if (acc != ACC_MAX) acc_next = acc + e_ext;
                    sat_next = sat | (acc_next == ACC_MAX);
                end
            end

            default: begin
                acc_next   = '0;
                sat_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            sat         <= 1'b0;
            count_hold  <= '0;
            ovf_hold    <= 1'b0;
            valid_pulse <= 1'b0;
            busy_flag   <= 1'b0;
        end else begin
            state       <= state_next;
            acc         <= acc_next;
            sat         <= sat_next;
            valid_pulse <= close;
            busy_flag   <= (state_next != IDLE);
            if (close) begin
                count_hold <= acc;
                ovf_hold   <= sat;
            end
        end
    end

    assign bus.count = count_hold;
    assign bus.ovf   = ovf_hold;
    assign bus.valid = valid_pulse;
    assign bus.busy  = busy_flag;

endmodule
